hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. It sits beside the ID stage and tracks the destination registers of in-flight instructions in EX, MEM and WB. From that tracking it drives the load-use stall and bubble, the multi-cycle divide freeze, the registered EX operand-forwarding selects, and the same-cycle WB→ID register-file bypass. It owns no datapath; it only sequences the register file, forwarding muxes and pipeline registers.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_ctrl_div_busy_timer.sv | 66 ++++++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the RV32 pipeline hazard controller.
//               fwd_sel_t   - EX operand source select
//               slot_t      - tracking record for one in-flight instruction
//               div_state_t - divide busy-timer states
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,  // register-file / ID/EX operand
    FWD_MEM  = 2'd1,  // EX/MEM result
    FWD_WB   = 2'd2   // MEM/WB result
  } fwd_sel_t;

  typedef struct packed {
    logic       v;     // slot holds a real instruction
    logic [4:0] rd;    // destination register
    logic       we;    // rd write enable captured at issue
    logic       load;  // instruction is a load
    logic       div;   // instruction is a divide/remainder
  } slot_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  localparam slot_t SLOT_EMPTY = '0;

  // True when slot s will write register r. x0 never counts as a write.
  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.v & s.we & (s.rd != 5'd0) & (s.rd == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_div_busy_timer.sv
`default_nettype none
// ============================================================================
// Module      : div_busy_timer
// Description : Holds EX frozen while a multi-cycle divide executes.
//               The first stall cycle is signalled from IDLE (combinationally
//               on start), so the total stall is DIV_LAT-1 cycles.
// Ports       : clk, rst_n (async active-low)
//               start - a divide currently occupies EX
//               busy  - freeze the pipeline this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module div_busy_timer #(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);
  import hazard_pkg::*;

  // A 1-cycle divide never stalls; keep the counter at least one bit wide.
  localparam int             CNT_W    = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam bit             MULTI    = (DIV_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LAT - 2);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start && MULTI) begin
          busy      = 1'b1;
          state_nxt = DIV_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      DIV_BUSY: begin
        if (cnt != '0) begin
          busy    = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          // Final cycle: the divide leaves EX on this edge.
          state_nxt = DIV_IDLE;
        end
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the 5-stage RV32 core. Tracks the
//               destinations of instructions in EX/MEM/WB and produces the
//               load-use stall/bubble, divide freeze, registered EX forward
//               selects and the WB->ID register-file bypass.
// Ports       : clk, rst_n (async active-low)
//               id_*        - decoded fields of the instruction in ID
//               flush       - EX redirect, kills the ID instruction
//               stall_if_id - hold PC and IF/ID
//               bubble_ex   - load a NOP into ID/EX
//               stall_ex    - freeze all pipeline registers (divide)
//               ex_fwd_a/b  - EX operand source (fwd_sel_t encoding)
//               id_byp_a/b  - ID operand takes WB write data
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rd_we,
  input  logic       id_is_load,
  input  logic       id_is_div,
  input  logic       flush,
  output logic       stall_if_id,
  output logic       bubble_ex,
  output logic       stall_ex,
  output logic [1:0] ex_fwd_a,
  output logic [1:0] ex_fwd_b,
  output logic       id_byp_a,
  output logic       id_byp_b
);
  import hazard_pkg::*;

  slot_t    s_ex, s_mem, s_wb;
  slot_t    id_slot;
  fwd_sel_t fwd_a_q, fwd_b_q;
  logic     lu;
  logic     issue;

  // Select for one source at issue: the instruction now in EX will be in MEM
  // when this one reaches EX, and the one now in MEM will be in WB.
  function automatic fwd_sel_t fwd_pick(input logic used, input logic [4:0] rs,
                                        input slot_t ex, input slot_t mem);
    if (!used || rs == 5'd0) return FWD_NONE;
    if (writes(ex, rs))      return FWD_MEM;
    if (writes(mem, rs))     return FWD_WB;
    return FWD_NONE;
  endfunction

  assign id_slot = {1'b1, id_rd, id_rd_we, id_is_load, id_is_div};

  assign lu = id_valid & s_ex.load &
              ((id_rs1_used & writes(s_ex, id_rs1)) |
               (id_rs2_used & writes(s_ex, id_rs2)));

  assign stall_if_id = lu | stall_ex;
  assign bubble_ex   = lu & ~stall_ex & ~flush;
  assign issue       = id_valid & ~stall_if_id & ~flush;

  assign id_byp_a = id_rs1_used & (id_rs1 != 5'd0) & writes(s_wb, id_rs1);
  assign id_byp_b = id_rs2_used & (id_rs2 != 5'd0) & writes(s_wb, id_rs2);

  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;

  div_busy_timer #(
    .DIV_LAT (DIV_LAT)
  ) u_div_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s_ex.v & s_ex.div),
    .busy  (stall_ex)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ex    <= SLOT_EMPTY;
      s_mem   <= SLOT_EMPTY;
      s_wb    <= SLOT_EMPTY;
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else if (!stall_ex) begin
      s_wb    <= s_mem;
      s_mem   <= s_ex;
      s_ex    <= issue ? id_slot : SLOT_EMPTY;
      fwd_a_q <= issue ? fwd_pick(id_rs1_used, id_rs1, s_ex, s_mem) : FWD_NONE;
      fwd_b_q <= issue ? fwd_pick(id_rs2_used, id_rs2, s_ex, s_mem) : FWD_NONE;
    end
  end

  // A redirect cannot originate from EX while EX is frozen by a divide.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(flush && stall_ex));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances
//               (DIV_LAT=4 and DIV_LAT=8) share stimulus; each is compared
//               against a stage-list reference model every cycle, plus
//               directed checks for the key hazard scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int LAT0 = 4;
  localparam int LAT1 = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_div, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       sif [2];
  logic       bub [2];
  logic       sex [2];
  logic [1:0] fa  [2];
  logic [1:0] fb  [2];
  logic       ba  [2];
  logic       bb  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_div(id_is_div), .flush(flush),
    .stall_if_id(sif[0]), .bubble_ex(bub[0]), .stall_ex(sex[0]),
    .ex_fwd_a(fa[0]), .ex_fwd_b(fb[0]), .id_byp_a(ba[0]), .id_byp_b(bb[0])
  );

  hazard_ctrl #(.DIV_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_div(id_is_div), .flush(flush),
    .stall_if_id(sif[1]), .bubble_ex(bub[1]), .stall_ex(sex[1]),
    .ex_fwd_a(fa[1]), .ex_fwd_b(fb[1]), .id_byp_a(ba[1]), .id_byp_b(bb[1])
  );

  // ---------------- reference model: list of instructions per stage --------
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
    bit       dv;
  } ins_t;

  ins_t     m_ex [2], m_mem [2], m_wb [2];
  int       m_left [2];          // remaining freeze cycles for the divide in EX
  bit [1:0] m_fa [2], m_fb [2];
  bit       e_sif [2], e_bub [2], e_sex [2], e_ba [2], e_bb [2], e_issue [2];

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit hits(ins_t s, bit [4:0] r);
    return s.v && s.we && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic bit [1:0] pick(bit used, bit [4:0] rs, ins_t ex, ins_t mem);
    if (!used || rs == 5'd0) return 2'd0;
    if (hits(ex, rs))        return 2'd1;
    if (hits(mem, rs))       return 2'd2;
    return 2'd0;
  endfunction

  function automatic void eval(int k);
    bit lu, st;
    st = (m_left[k] > 0);
    lu = id_valid && m_ex[k].ld &&
         ((id_rs1_used && hits(m_ex[k], id_rs1)) || (id_rs2_used && hits(m_ex[k], id_rs2)));
    e_sex[k]   = st;
    e_sif[k]   = lu || st;
    e_bub[k]   = lu && !st && !flush;
    e_ba[k]    = id_rs1_used && (id_rs1 != 5'd0) && hits(m_wb[k], id_rs1);
    e_bb[k]    = id_rs2_used && (id_rs2 != 5'd0) && hits(m_wb[k], id_rs2);
    e_issue[k] = id_valid && !e_sif[k] && !flush;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      m_left[k] = 0; m_fa[k] = 2'd0; m_fb[k] = 2'd0;
    end
  endtask

  task automatic model_edge();
    ins_t nx;
    for (int k = 0; k < 2; k++) begin
      eval(k);
      if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
      end else begin
        m_fa[k]  = e_issue[k] ? pick(id_rs1_used, id_rs1, m_ex[k], m_mem[k]) : 2'd0;
        m_fb[k]  = e_issue[k] ? pick(id_rs2_used, id_rs2, m_ex[k], m_mem[k]) : 2'd0;
        nx       = e_issue[k] ? {1'b1, id_rd, id_rd_we, id_is_load, id_is_div} : '0;
        m_wb[k]  = m_mem[k];
        m_mem[k] = m_ex[k];
        m_ex[k]  = nx;
        m_left[k] = (nx.v && nx.dv) ? lat_of(k) - 1 : 0;
      end
    end
  endtask

  // ---------------- checking ------------------------------------------------
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      eval(k);
      chk($sformatf("u%0d.stall_if_id", k), 32'(sif[k]), 32'(e_sif[k]));
      chk($sformatf("u%0d.bubble_ex", k),   32'(bub[k]), 32'(e_bub[k]));
      chk($sformatf("u%0d.stall_ex", k),    32'(sex[k]), 32'(e_sex[k]));
      chk($sformatf("u%0d.ex_fwd_a", k),    32'(fa[k]),  32'(m_fa[k]));
      chk($sformatf("u%0d.ex_fwd_b", k),    32'(fb[k]),  32'(m_fb[k]));
      chk($sformatf("u%0d.id_byp_a", k),    32'(ba[k]),  32'(e_ba[k]));
      chk($sformatf("u%0d.id_byp_b", k),    32'(bb[k]),  32'(e_bb[k]));
    end
  endtask

  task automatic check_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d.outs", tag, k),
          32'({sif[k], bub[k], sex[k], fa[k], fb[k], ba[k], bb[k]}), 32'd0);
    end
  endtask

  // One clock: check at the falling edge, advance model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drive(bit v, bit [4:0] r1, bit u1, bit [4:0] r2, bit u2,
                       bit [4:0] rd, bit we, bit ld, bit dv, bit fl);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_is_div = dv; flush = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(int n);
    nop();
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nop();
    model_reset();

    // Reset state
    #2;
    check_zero("reset");
    #10 rst_n = 1'b1;            // released between edges
    @(posedge clk); #1;

    // Reset mid-divide: div in EX for 3 cycles, then async reset
    drive(1, 1, 1, 2, 1, 10, 1, 0, 1, 0);
    cycle();
    nop();
    cycle();
    cycle();
    chk("middiv.u0.stall_ex", 32'(sex[0]), 32'd1);
    chk("middiv.u1.stall_ex", 32'(sex[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    #3 rst_n = 1'b1;
    #1;
    chk("postrst.u0.stall_ex", 32'(sex[0]), 32'd0);
    chk("postrst.u1.stall_ex", 32'(sex[1]), 32'd0);
    @(posedge clk); #1;

    // ALU -> ALU: add x5,x1,x2 ; sub x6,x5,x3
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    cycle();
    drive(1, 5, 1, 3, 1, 6, 1, 0, 0, 0);
    #1 chk("alu.stall_if_id", 32'(sif[0]), 32'd0);
    cycle();
    chk("alu.ex_fwd_a", 32'(fa[0]), 32'(FWD_MEM));
    chk("alu.ex_fwd_b", 32'(fb[0]), 32'(FWD_NONE));
    drain(3);

    // Load-use: lw x6,0(x1) ; add x7,x6,x2
    drive(1, 1, 1, 0, 0, 6, 1, 1, 0, 0);
    cycle();
    drive(1, 6, 1, 2, 1, 7, 1, 0, 0, 0);
    #1;
    chk("lu.stall_if_id", 32'(sif[0]), 32'd1);
    chk("lu.bubble_ex",   32'(bub[0]), 32'd1);
    cycle();
    chk("lu.stall_after", 32'(sif[0]), 32'd0);
    cycle();
    chk("lu.ex_fwd_a", 32'(fa[0]), 32'(FWD_WB));
    drain(3);

    // WB bypass: writer of x9, two NOPs, or x4,x0,x9
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
    cycle();
    drain(2);
    drive(1, 0, 1, 9, 1, 4, 1, 0, 0, 0);
    #1;
    chk("byp.id_byp_b", 32'(bb[0]), 32'd1);
    chk("byp.id_byp_a", 32'(ba[0]), 32'd0);
    cycle();
    drain(3);

    // Divide (DIV_LAT=4 instance): div x10,x1,x2 ; add x11,x10,x0
    drive(1, 1, 1, 2, 1, 10, 1, 0, 1, 0);
    cycle();
    drive(1, 10, 1, 0, 1, 11, 1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (sex[0] !== 1'b1) break;
      n++;
      cycle();
    end
    chk("div.stall_cycles", 32'(n), 32'(LAT0 - 1));
    cycle();
    chk("div.ex_fwd_a", 32'(fa[0]), 32'(FWD_MEM));
    chk("div.ex_fwd_b", 32'(fb[0]), 32'(FWD_NONE));
    drain(LAT1 + 3);

    // Flush together with a load-use condition
    drive(1, 1, 1, 0, 0, 6, 1, 1, 0, 0);
    cycle();
    drive(1, 6, 1, 2, 1, 7, 1, 0, 0, 1);
    #1 chk("flush.bubble_ex", 32'(bub[0]), 32'd0);
    cycle();
    drive(1, 6, 1, 2, 1, 7, 1, 0, 0, 0);
    #1 chk("flush.no_stall_next", 32'(sif[0]), 32'd0);
    cycle();
    drain(3);

    // lw x0 followed by a reader of x0
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    cycle();
    drive(1, 0, 1, 0, 1, 7, 1, 0, 0, 0);
    #1 chk("x0.no_stall", 32'(sif[0]), 32'd0);
    cycle();
    drain(3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit ld, dv, fl;
      ld = ($urandom % 4) == 0;
      dv = !ld && (($urandom % 16) == 0);
      fl = (m_left[0] == 0) && (m_left[1] == 0) && (($urandom % 10) == 0);
      drive(($urandom % 8) != 0,
            5'($urandom_range(0, 7)), 1'($urandom % 2),
            5'($urandom_range(0, 7)), 1'($urandom % 2),
            5'($urandom_range(0, 7)), ($urandom % 4) != 0, ld, dv, fl);
      cycle();
    end
    drain(LAT1 + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
